// File: rtl/lsu_subword_bridge.sv
// lsu_subword_bridge
//   Load/store bridge between the core memory stage and a word-organised data
//   memory (combinational read, synchronous write). Adds byte/halfword loads
//   with sign/zero extension and byte/halfword stores by read-modify-write.
//
//   Handshake: the core raises cpu_req while the bridge is idle and holds it
//   until cpu_done. The request is sampled only in IDLE; cpu_done is a
//   one-cycle pulse and cpu_error qualifies it (rejected, no memory write).
//
//   Ports
//     clk, reset            clock, synchronous active-low reset
//     cpu_req/cpu_write     request strobe, 1 = store
//     cpu_funct3            RISC-V size/sign encoding
//     cpu_address           byte address
//     cpu_write_data        store data (low byte/halfword for SB/SH)
//     cpu_read_data         extended load result, held until next good load
//     cpu_done/cpu_error    completion pulse and its error qualifier
//     cpu_busy              high outside IDLE
//     mem_*                 word-granular memory port
//     dbg_state             current FSM state (0 IDLE,1 ACCESS,2 WRITE,3 DONE)
//
//   Build option: define LSU_ALIGN_CHECK_EN to reject misaligned halfword and
//   word accesses; otherwise the low address bits are silently ignored.
module lsu_subword_bridge #(
  parameter int MEMORY_SIZE = 4096
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_req,
  input  logic        cpu_write,
  input  logic [2:0]  cpu_funct3,
  input  logic [31:0] cpu_address,
  input  logic [31:0] cpu_write_data,
  output logic [31:0] cpu_read_data,
  output logic        cpu_done,
  output logic        cpu_error,
  output logic        cpu_busy,
  output logic        mem_read,
  output logic        mem_write,
  output logic [31:0] mem_address,
  output logic [31:0] mem_write_data,
  input  logic [31:0] mem_read_data,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_WRITE  = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t      r_state;
  logic        r_write;
  logic [2:0]  r_funct3;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [31:0] r_merge;
  logic [31:0] r_read_data;
  logic        r_done;
  logic        r_error;

  logic        w_f3_ok;
  logic        w_range_ok;
  logic        w_misalign;
  logic        w_req_err;
  logic        w_is_sw;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_load;
  logic [31:0] w_merge;

  // Request legality, evaluated on the raw inputs while IDLE.
  always_comb begin
    w_f3_ok = 1'b0;
    if (cpu_write) begin
      w_f3_ok = (cpu_funct3 == 3'b000) || (cpu_funct3 == 3'b001) ||
                (cpu_funct3 == 3'b010);
    end else begin
      w_f3_ok = (cpu_funct3 == 3'b000) || (cpu_funct3 == 3'b001) ||
                (cpu_funct3 == 3'b010) || (cpu_funct3 == 3'b100) ||
                (cpu_funct3 == 3'b101);
    end
  end

  assign w_range_ok = (cpu_address < 32'(MEMORY_SIZE));

`ifdef LSU_ALIGN_CHECK_EN
  assign w_misalign = ((cpu_funct3[1:0] == 2'b01) && cpu_address[0]) ||
                      ((cpu_funct3[1:0] == 2'b10) && (cpu_address[1:0] != 2'b00));
`else
  assign w_misalign = 1'b0;
`endif

  assign w_req_err = !w_f3_ok || !w_range_ok || w_misalign;
  assign w_is_sw   = r_write && (r_funct3 == 3'b010);

  // Little-endian lane selection from the combinational read data.
  assign w_byte = mem_read_data[{r_addr[1:0], 3'b000} +: 8];
  assign w_half = r_addr[1] ? mem_read_data[31:16] : mem_read_data[15:0];

  always_comb begin
    w_load = mem_read_data;
    case (r_funct3)
      3'b000:  w_load = {{24{w_byte[7]}}, w_byte};
      3'b001:  w_load = {{16{w_half[15]}}, w_half};
      3'b100:  w_load = {24'd0, w_byte};
      3'b101:  w_load = {16'd0, w_half};
      default: w_load = mem_read_data;
    endcase
  end

  // Old word with only the target lane replaced by the store data.
  always_comb begin
    w_merge = r_merge;
    if (r_funct3[1:0] == 2'b00) begin
      w_merge[{r_addr[1:0], 3'b000} +: 8] = r_wdata[7:0];
    end else if (r_addr[1]) begin
      w_merge[31:16] = r_wdata[15:0];
    end else begin
      w_merge[15:0] = r_wdata[15:0];
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_write     <= 1'b0;
      r_funct3    <= 3'd0;
      r_addr      <= 32'd0;
      r_wdata     <= 32'd0;
      r_merge     <= 32'd0;
      r_read_data <= 32'd0;
      r_done      <= 1'b0;
      r_error     <= 1'b0;
    end else begin
      r_done  <= 1'b0;
      r_error <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (cpu_req) begin
            r_write  <= cpu_write;
            r_funct3 <= cpu_funct3;
            r_addr   <= cpu_address;
            r_wdata  <= cpu_write_data;
            if (w_req_err) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
              r_error <= 1'b1;
            end else begin
              r_state <= S_ACCESS;
            end
          end
        end
        S_ACCESS: begin
          if (!r_write) begin
            r_read_data <= w_load;
            r_state     <= S_DONE;
            r_done      <= 1'b1;
          end else if (w_is_sw) begin
            r_state <= S_DONE;
            r_done  <= 1'b1;
          end else begin
            r_merge <= mem_read_data;
            r_state <= S_WRITE;
          end
        end
        S_WRITE: begin
          r_state <= S_DONE;
          r_done  <= 1'b1;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Strobes are gated by reset so an edge with reset low never writes memory.
  assign mem_read  = reset && (r_state == S_ACCESS);
  assign mem_write = reset && (((r_state == S_ACCESS) && w_is_sw) ||
                               (r_state == S_WRITE));

  always_comb begin
    mem_write_data = 32'd0;
    if ((r_state == S_ACCESS) && w_is_sw) begin
      mem_write_data = r_wdata;
    end else if (r_state == S_WRITE) begin
      mem_write_data = w_merge;
    end
  end

  assign mem_address   = {r_addr[31:2], 2'b00};
  assign cpu_read_data = r_read_data;
  assign cpu_done      = r_done;
  assign cpu_error     = r_error;
  assign cpu_busy      = (r_state != S_IDLE);
  assign dbg_state     = r_state;

endmodule

// File: doc/lsu_subword_bridge.md
Name: lsu_subword_bridge

Overview:
- Load/store bridge between the core's memory stage and the word-organised data memory.
- The memory has a combinational read port, a synchronous write port and word granularity only.
- The bridge adds byte and halfword loads with sign/zero extension, and byte and halfword stores via read-modify-write.
- It replaces direct core-to-memory wiring with a request/done handshake.

Parameters:
- MEMORY_SIZE, 4096: data memory size in bytes. Any access with address >= MEMORY_SIZE is an error.

Ports:
- clk  input  1  clock
- reset  input  1  synchronous, active-low reset
- cpu_req  input  1  access request; sampled only in IDLE
- cpu_write  input  1  1 = store, 0 = load
- cpu_funct3  input  3  RISC-V funct3 (size and sign)
- cpu_address  input  32  byte address
- cpu_write_data  input  32  store data; low byte or halfword is used for SB/SH
- cpu_read_data  output  32  extended load result (registered)
- cpu_done  output  1  one-cycle completion pulse
- cpu_error  output  1  qualifies cpu_done: access rejected, no memory write occurred
- cpu_busy  output  1  high in every state except IDLE
- mem_read  output  1  to memory_read
- mem_write  output  1  to memory_write
- mem_address  output  32  word-aligned address ({addr[31:2],2'b00})
- mem_write_data  output  32  to write_data
- mem_read_data  input  32  from read_data (combinational)

Behaviour:
- FSM states: IDLE, ACCESS, WRITE, DONE.
- Reset (reset sampled low, any state):
  - state goes to IDLE.
  - cpu_read_data, cpu_done, cpu_error and the latched request registers all clear to 0.
  - mem_read and mem_write are gated by reset, so no memory write happens on an edge where reset is low. An in-flight RMW is abandoned with memory unchanged.
- IDLE:
  - On cpu_req=1, latch write, funct3, address and write_data.
  - Legal in-range request: go to ACCESS.
  - Illegal funct3 (loads 011/110/111; stores other than 000/001/010) or address >= MEMORY_SIZE: go directly to DONE with error=1.
  - cpu_req outside IDLE is ignored; the core holds it until done.
- ACCESS:
  - mem_read=1; mem_address comes from the latched address.
  - Load: extract the lane from mem_read_data (little-endian; byte lane addr[1:0], halfword lane addr[1]). Sign-extend for 000/001, zero-extend for 100/101. Register into cpu_read_data; go to DONE.
  - SW: mem_write=1 with mem_write_data = latched data; go to DONE.
  - SB/SH: capture mem_read_data into the merge register; go to WRITE.
- WRITE:
  - mem_write=1.
  - mem_write_data = merge register with the target lane replaced by the latched data's low byte/halfword; other lanes preserved.
  - Go to DONE.
- DONE:
  - cpu_done=1 for exactly one cycle; cpu_error as latched; go to IDLE.
- Latency (req in IDLE cycle N):
  - done in N+2 for loads and SW.
  - done in N+3 for SB/SH.
  - done in N+1 for errors.
  - Back-to-back: the next req is accepted in the IDLE cycle following DONE.
- Output holds:
  - cpu_read_data holds its value until the next successful load completes; stores and errors do not alter it.
- Output defaults:
  - mem_read, mem_write and mem_write_data are 0 in IDLE and DONE.
  - mem_address is always driven from the latched address.

Optional Feature:
- Macro: LSU_ALIGN_CHECK_EN.
- Defined:
  - Halfword access with addr[0]=1 is an error: done in N+1 with cpu_error=1, no mem_read/mem_write.
  - Word access with addr[1:0]!=0 is the same error.
- Undefined:
  - Misaligned accesses are silently aligned: halfword ignores addr[0]; word ignores addr[1:0].
  - Only illegal funct3 and out-of-range addresses raise cpu_error.

Test Plan:
- Reset low for 2 cycles while in WRITE of an SB to 0x20 (word 0xDEADBEEF) -> state IDLE, all outputs 0, word 0x20 still 0xDEADBEEF.
- SW 0x11223344 @0x10, then LW @0x10 -> done at N+2 each, cpu_read_data=0x11223344, cpu_error=0.
- LB @0x13 -> 0x00000011; LB @0x10 after SW 0x00000080 -> 0xFFFFFF80; LBU same -> 0x00000080; LH @0x12 of 0x8001FFFF -> 0xFFFF8001.
- SB 0xAB @0x11 over 0x11223344 -> done at N+3, word 0x1122AB44. SH 0xCAFE @0x12 -> 0xCAFEAB44.
- LW @0x1000 (MEMORY_SIZE=4096) or funct3=011 load -> done at N+1, cpu_error=1, mem_write never high, cpu_read_data unchanged.
- With LSU_ALIGN_CHECK_EN, SH @0x11 -> error at N+1, memory unchanged. Without it, SH 0xBEEF @0x11 writes the lane at 0x10, done at N+3, cpu_error=0.
